pipe_csa_sub128: RTL and testbench

- Pipelined, handshaked 128-bit subtractor: D = A - B - BIN.
- Internally computes A + ~B + ~BIN using 4-bit carry-select blocks. The carry between the 32-bit slices is registered, one slice per stage.
- Serves as the subtract-side counterpart to the combinational add-one carry-select adders in the datapath library.
- Sits between an operand source and a result sink, both using valid/ready handshakes.

---
 rtl/pipe_csa_sub128.sv | 161 ++++++++++++++++
 tb/tb_pipe_csa_sub128.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_csa_sub128.sv
// Pipelined valid/ready 128-bit subtractor, D = A - B - BIN, built from 4-bit carry-select blocks.
// Define PIPE_CSA_SUB_ADDSUB_EN to add an 'op' input that selects addition (op=1) per beat.
module pipe_csa_sub128 #(
  parameter int N      = 128,
  parameter int SLICE  = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
`ifdef PIPE_CSA_SUB_ADDSUB_EN
  input  logic         op,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         ovf
);

  localparam int L = STAGES - 1;

  // Slice adder: each 4-bit block precomputes both carry-in results, the rippling carry picks one.
  function automatic logic [SLICE:0] csaSlice(input logic [SLICE-1:0] x,
                                              input logic [SLICE-1:0] y,
                                              input logic             cin);
    logic             c;
    logic [SLICE-1:0] s;
    logic [4:0]       s0;
    logic [4:0]       s1;
    c = cin;
    s = '0;
    for (int j = 0; j < SLICE / 4; j++) begin
      s0 = {1'b0, x[4*j +: 4]} + {1'b0, y[4*j +: 4]};
      s1 = {1'b0, x[4*j +: 4]} + {1'b0, y[4*j +: 4]} + 5'd1;
      s[4*j +: 4] = c ? s1[3:0] : s0[3:0];
      c = c ? s1[4] : s0[4];
    end
    return {c, s};
  endfunction

  logic         r_valid [STAGES];
  logic [N-1:0] r_a     [STAGES];
  logic [N-1:0] r_bx    [STAGES];
  logic [N-1:0] r_d     [STAGES];
  logic         r_c     [STAGES];
  logic         r_op    [STAGES];
  logic         r_bout;
  logic         r_ovf;

  logic         w_sValid [STAGES];
  logic [N-1:0] w_sA     [STAGES];
  logic [N-1:0] w_sBx    [STAGES];
  logic [N-1:0] w_sD     [STAGES];
  logic         w_sC     [STAGES];
  logic         w_sOp    [STAGES];
  logic [SLICE:0] w_slice [STAGES];

  logic         w_nValid [STAGES];
  logic [N-1:0] w_nA     [STAGES];
  logic [N-1:0] w_nBx    [STAGES];
  logic [N-1:0] w_nD     [STAGES];
  logic         w_nC     [STAGES];
  logic         w_nOp    [STAGES];
  logic         w_nBout;
  logic         w_nOvf;

  logic         w_op0;
  logic         w_stall;

`ifdef PIPE_CSA_SUB_ADDSUB_EN
  assign w_op0 = op;
`else
  assign w_op0 = 1'b0;
`endif

  // A single stall freezes the whole pipe, so a stalled result simply stays on the outputs.
  assign w_stall   = r_valid[L] & ~out_ready;
  assign in_ready  = ~w_stall;
  assign out_valid = r_valid[L];
  assign d         = r_d[L];
  assign bout      = r_bout;
  assign ovf       = r_ovf;

  // Stage sources: stage 0 sees the (conditionally inverted) operands, later stages see the previous register.
  always_comb begin
    w_sValid[0] = in_valid;
    w_sA[0]     = a;
    w_sBx[0]    = w_op0 ? b : ~b;
    w_sC[0]     = w_op0 ? bin : ~bin;
    w_sD[0]     = '0;
    w_sOp[0]    = w_op0;
    for (int k = 1; k < STAGES; k++) begin
      w_sValid[k] = r_valid[k-1];
      w_sA[k]     = r_a[k-1];
      w_sBx[k]    = r_bx[k-1];
      w_sC[k]     = r_c[k-1];
      w_sD[k]     = r_d[k-1];
      w_sOp[k]    = r_op[k-1];
    end
  end

  // Each stage resolves its own slice; bubbles load zeros so idle operand values never reach the outputs.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_slice[k]  = csaSlice(w_sA[k][k*SLICE +: SLICE], w_sBx[k][k*SLICE +: SLICE], w_sC[k]);
      w_nValid[k] = w_sValid[k];
      w_nA[k]     = w_sA[k];
      w_nBx[k]    = w_sBx[k];
      w_nOp[k]    = w_sOp[k];
      w_nC[k]     = w_slice[k][SLICE];
      w_nD[k]     = w_sD[k];
      w_nD[k][k*SLICE +: SLICE] = w_slice[k][SLICE-1:0];
      if (!w_sValid[k]) begin
        w_nA[k]  = '0;
        w_nBx[k] = '0;
        w_nOp[k] = 1'b0;
        w_nC[k]  = 1'b0;
        w_nD[k]  = '0;
      end
    end
  end

  // With bx already inverted for subtraction, one overflow form covers both add and subtract.
  always_comb begin
    w_nBout = w_nValid[L] & (w_nC[L] ^ ~w_nOp[L]);
    w_nOvf  = w_nValid[L] & ~(w_nA[L][N-1] ^ w_nBx[L][N-1]) & (w_nD[L][N-1] ^ w_nA[L][N-1]);
  end

  // Pipeline registers: async clear, otherwise advance one stage per unstalled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_a[k]     <= '0;
        r_bx[k]    <= '0;
        r_d[k]     <= '0;
        r_c[k]     <= 1'b0;
        r_op[k]    <= 1'b0;
      end
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (!w_stall) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_nValid[k];
        r_a[k]     <= w_nA[k];
        r_bx[k]    <= w_nBx[k];
        r_d[k]     <= w_nD[k];
        r_c[k]     <= w_nC[k];
        r_op[k]    <= w_nOp[k];
      end
      r_bout <= w_nBout;
      r_ovf  <= w_nOvf;
    end
  end

endmodule

// File: tb/tb_pipe_csa_sub128.sv
// Self-checking bench for pipe_csa_sub128: directed cases, streaming, backpressure and reset,
// with a queue scoreboard fed from an arithmetic reference model.
module tb_pipe_csa_sub128;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] a;
  logic [127:0] b;
  logic         bin;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] d;
  logic         bout;
  logic         ovf;

  int checks;
  int errors;
  int popCount;
  logic [129:0] sbQueue[$];

  pipe_csa_sub128 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
`ifdef PIPE_CSA_SUB_ADDSUB_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: exact 129-bit arithmetic, returns {ovf, bout, d}.
  function automatic logic [129:0] model(input logic [127:0] ma, input logic [127:0] mb,
                                         input logic mbin, input logic mop);
    logic [128:0] full;
    logic         mOvf;
    if (mop) begin
      full = {1'b0, ma} + {1'b0, mb} + {128'd0, mbin};
      mOvf = ~(ma[127] ^ mb[127]) & (full[127] ^ ma[127]);
    end else begin
      full = {1'b0, ma} - {1'b0, mb} - {128'd0, mbin};
      mOvf = (ma[127] ^ mb[127]) & (full[127] ^ ma[127]);
    end
    return {mOvf, full[128], full[127:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Scoreboard: pop and compare on output transfers, push the model result on input transfers.
  always @(negedge clk) begin
    if (rst) begin
      sbQueue.delete();
    end else begin
      if (out_valid && out_ready) begin
        checkFlag("sb_beat_expected", sbQueue.size() != 0, 1'b1);
        if (sbQueue.size() != 0) begin
          logic [129:0] exp;
          exp = sbQueue.pop_front();
          checkOutput("sb_d", d, exp[127:0]);
          checkFlag("sb_bout", bout, exp[128]);
          checkFlag("sb_ovf", ovf, exp[129]);
          popCount++;
        end
      end
      if (in_valid && in_ready) sbQueue.push_back(model(a, b, bin, op));
    end
  end

  task automatic applyStimulus(input logic v, input logic [127:0] ta, input logic [127:0] tb,
                               input logic tbin, input logic top, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = ta;
    b         = tb;
    bin       = tbin;
    op        = top;
    out_ready = ordy;
    #1;
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One isolated beat: output must appear exactly four cycles after the input transfer.
  task automatic runSingle(input string tag, input logic [127:0] ta, input logic [127:0] tb,
                           input logic tbin, input logic top,
                           input logic [127:0] ed, input logic eb, input logic eo);
    applyStimulus(1'b1, ta, tb, tbin, top, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkFlag({tag, "_early_valid"}, out_valid, 1'b0);
      checkFlag({tag, "_in_ready"}, in_ready, 1'b1);
      waitCycle();
    end
    checkFlag({tag, "_valid"}, out_valid, 1'b1);
    checkOutput({tag, "_d"}, d, ed);
    checkFlag({tag, "_bout"}, bout, eb);
    checkFlag({tag, "_ovf"}, ovf, eo);
    waitCycle();
    checkFlag({tag, "_done"}, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the bench finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] allOnes;
    logic [127:0] minNeg;
    logic [127:0] bit96;
    logic [127:0] rv;
    logic [127:0] savedD;
    logic         stalled;
    logic [3:0]   readyPattern;
    int           popBase;

    allOnes      = '1;
    minNeg       = 128'd1 << 127;
    bit96        = 128'd1 << 96;
    readyPattern = 4'b1001;
    checks       = 0;
    errors       = 0;
    popCount     = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    a            = '0;
    b            = '0;
    bin          = 1'b0;
    op           = 1'b0;
    out_ready    = 1'b1;

    @(posedge clk);
    #2;
    checkFlag("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_d", d, '0);
    checkFlag("reset_bout", bout, 1'b0);
    checkFlag("reset_ovf", ovf, 1'b0);
    checkFlag("reset_in_ready", in_ready, 1'b1);
    waitCycle();
    rst = 1'b0;

    runSingle("sub_5_3", 128'd5, 128'd3, 1'b0, 1'b0, 128'd2, 1'b0, 1'b0);
    runSingle("sub_0_1", '0, 128'd1, 1'b0, 1'b0, allOnes, 1'b1, 1'b0);
    runSingle("sub_minneg_1", minNeg, 128'd1, 1'b0, 1'b0, minNeg - 128'd1, 1'b0, 1'b1);
    runSingle("sub_borrow96", bit96, 128'd1, 1'b0, 1'b0, bit96 - 128'd1, 1'b0, 1'b0);
    rv = rand128();
    runSingle("sub_equal", rv, rv, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    runSingle("sub_wrap", '0, '0, 1'b1, 1'b0, allOnes, 1'b1, 1'b0);

    // Back-to-back stream of 20 beats, one result per cycle.
    popBase = popCount;
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, rand128(), rand128(), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    waitCycle();
    waitCycle();
    waitCycle();
    checkOutput("stream_pops_before_last", 128'(popCount - popBase), 128'd19);
    checkFlag("stream_last_valid", out_valid, 1'b1);
    waitCycle();
    checkOutput("stream_pops_total", 128'(popCount - popBase), 128'd20);
    checkFlag("stream_drained", out_valid, 1'b0);

    // Backpressure with out_ready cycling 1,0,0,1.
    stalled = 1'b0;
    savedD  = '0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, rand128(), rand128(), 1'($urandom_range(0, 1)), 1'b0, readyPattern[i % 4]);
      if (stalled) begin
        checkOutput("stall_d_hold", d, savedD);
        checkFlag("stall_valid_hold", out_valid, 1'b1);
      end
      stalled = out_valid & ~out_ready;
      checkFlag("bp_in_ready", in_ready, ~stalled);
      savedD = d;
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) waitCycle();
    checkFlag("bp_drained", sbQueue.size() == 0, 1'b1);

    // Idle operand values must not produce output.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, rand128(), rand128(), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      checkFlag("idle_no_output", out_valid, 1'b0);
    end

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, rand128(), rand128(), 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    checkFlag("midreset_valid_now", out_valid, 1'b0);
    checkFlag("midreset_in_ready", in_ready, 1'b1);
    waitCycle();
    checkFlag("midreset_valid_edge", out_valid, 1'b0);
    checkOutput("midreset_d", d, '0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      waitCycle();
      checkFlag("post_reset_no_stale", out_valid, 1'b0);
    end

`ifdef PIPE_CSA_SUB_ADDSUB_EN
    runSingle("add_wrap", allOnes, 128'd1, 1'b0, 1'b1, '0, 1'b1, 1'b0);
    runSingle("add_ovf", minNeg - 128'd1, 128'd1, 1'b0, 1'b1, minNeg, 1'b0, 1'b1);
`endif
    runSingle("sub_after_reset", 128'd100, 128'd40, 1'b1, 1'b0, 128'd59, 1'b0, 1'b0);

    checkFlag("final_queue_empty", sbQueue.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
